// File: rtl/subword_store_sequencer.sv
// Read-merge-write sequencer for SB/SH stores against a word-only data memory.
// Optional misaligned-SH trap is compiled in with `define MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | waiting for a store request
// READ  | reading the target word, held while mem_waitrequest
// MERGE | inserting the byte/halfword into the captured word
// WRITE | writing the merged word back, held while mem_waitrequest
// DONE  | one-cycle completion pulse, pipeline released
// ERR   | one-cycle misalign pulse, no memory access (trap build only)
module subword_store_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  req,
    input  logic                  req_half,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_waitrequest,
    output logic                  stall,
    output logic                  done,
    output logic                  misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE
`ifdef MISALIGN_TRAP_EN
        , S_ERR
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             data_q, data_d;
    logic                    half_q, half_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;

    // Only the low halfword of the store data is ever merged.
    logic unused_data_bits;
    assign unused_data_bits = ^req_data[DATA_WIDTH-1:16];

    function automatic logic [31:0] merge_word(input logic [31:0] w,
                                               input logic [15:0] d,
                                               input logic        half,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = w;
        if (half) begin
            if (lane[1]) r[31:16] = d;
            else         r[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            half_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            half_q  <= half_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        half_d  = half_q;
        word_d  = word_q;
        if (clk_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_d  = req_addr;
                        data_d  = req_data[15:0];
                        half_d  = req_half;
                        state_d = S_READ;
`ifdef MISALIGN_TRAP_EN
                        if (req_half && req_addr[0]) state_d = S_ERR;
`endif
                    end
                end
                S_READ: begin
                    if (!mem_waitrequest) begin
                        word_d  = mem_readdata;
                        state_d = S_MERGE;
                    end
                end
                S_MERGE: begin
                    word_d  = merge_word(word_q, data_q, half_q, addr_q[1:0]);
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (!mem_waitrequest) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read      = (state_q == S_READ);
        mem_write     = (state_q == S_WRITE);
        mem_address   = '0;
        mem_writedata = '0;
        if (mem_read || mem_write) mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        if (mem_write)             mem_writedata = word_q;
        done  = (state_q == S_DONE);
        // DONE/ERR release the pipeline even though req is still held high.
        stall = (req && state_q == S_IDLE) || mem_read || mem_write ||
                (state_q == S_MERGE);
`ifdef MISALIGN_TRAP_EN
        misalign = (state_q == S_ERR);
`else
        misalign = 1'b0;
`endif
    end

endmodule

// File: tb/tb_subword_store_sequencer.sv
// Self-checking bench for subword_store_sequencer: directed table, hand sequences
// and randomized stores checked against a byte-array reference model.
module tb_subword_store_sequencer;

    logic        clk = 1'b0;
    logic        reset, clk_enable, req, req_half;
    logic [31:0] req_addr, req_data;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;
    logic        stall, done, misalign;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [16];

    subword_store_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .req(req),
        .req_half(req_half), .req_addr(req_addr), .req_data(req_data),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .stall(stall), .done(done),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        half;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init;
        int          rw;
        int          ww;
        int          gap;
        logic [31:0] exp_word;
        int          exp_lat;
        logic        exp_trap;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: little-endian byte array update from the store rules.
    function automatic logic [31:0] ref_store(input logic [31:0] init, input logic half,
                                              input logic [1:0] lane, input logic [31:0] data);
        logic [7:0] b [4];
        int base;
        for (int i = 0; i < 4; i++) b[i] = init[8*i +: 8];
        if (half) begin
            base = (lane >= 2) ? 2 : 0;
            b[base]     = data[7:0];
            b[base + 1] = data[15:8];
        end else begin
            b[lane] = data[7:0];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Called on a negedge; issues one store and plays the memory side.
    task automatic do_store(input logic half, input logic [31:0] addr, input logic [31:0] data,
                            input int rw, input int ww, input int gap,
                            input logic [31:0] exp_word, input int exp_lat,
                            input logic exp_trap, input string tag);
        int cyc = 0, stall_n = 0, n_rd = 0, n_wr = 0, bad_excl = 0, bad_addr = 0, gl = 0;
        int rd_left = rw, wr_left = ww;
        logic [31:0] wrote = '0;
        logic [31:0] aligned;
        logic got_done = 1'b0, got_mis = 1'b0, gap_done = 1'b0, stall_end = 1'b1;
        aligned  = {addr[31:2], 2'b00};
        req      = 1'b1;
        req_half = half;
        req_addr = addr;
        req_data = data;
        #1;
        if (stall) stall_n++;
        while (!got_done && !got_mis && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gl > 0) begin
                gl--;
                if (gl == 0) clk_enable = 1'b1;
            end
            mem_waitrequest = 1'b0;
            if (mem_read && mem_write) bad_excl++;
            if (!mem_read && !mem_write && mem_address != 0) bad_addr++;
            if ((mem_read || mem_write) && mem_address !== aligned) bad_addr++;
            if (done) got_done = 1'b1;
            if (misalign) got_mis = 1'b1;
            if (got_done || got_mis) stall_end = stall;
            else if (stall) stall_n++;
            if (mem_read) begin
                mem_readdata = mem[addr[5:2]];
                if (rd_left > 0) begin
                    mem_waitrequest = 1'b1;
                    rd_left--;
                end else n_rd++;
            end
            if (mem_write) begin
                if (wr_left > 0) begin
                    mem_waitrequest = 1'b1;
                    wr_left--;
                end else begin
                    n_wr++;
                    wrote = mem_writedata;
                    mem[addr[5:2]] = mem_writedata;
                end
            end
            if (gap > 0 && !gap_done && stall && !mem_read && !mem_write && !done && !misalign) begin
                clk_enable = 1'b0;
                gl = gap;
                gap_done = 1'b1;
            end
        end
        req = 1'b0;
        mem_waitrequest = 1'b0;
        clk_enable = 1'b1;
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " stall_cycles"}, stall_n, exp_lat);
        chk({tag, " stall_at_end"}, stall_end, 0);
        chk({tag, " misalign_seen"}, got_mis, exp_trap);
        chk({tag, " done_seen"}, got_done, !exp_trap);
        chk({tag, " reads"}, n_rd, exp_trap ? 0 : 1);
        chk({tag, " writes"}, n_wr, exp_trap ? 0 : 1);
        if (!exp_trap) chk({tag, " word"}, wrote, exp_word);
        chk({tag, " strobe_overlap"}, bad_excl, 0);
        chk({tag, " address"}, bad_addr, 0);
        @(negedge clk);
        chk({tag, " pulse_end"}, {done, misalign, mem_read, mem_write, stall}, 0);
    endtask

    vec_t vecs [8];

    initial begin
        int n, wseen, idx, rw, ww, gap;
        logic [1:0]  lane;
        logic        half;
        logic [31:0] addr, data, init;

        vecs[0] = '{1'b0, 32'h1002, 32'h000000AB, 32'h11223344, 0, 0, 0, 32'h11AB3344, 4, 1'b0};
        vecs[1] = '{1'b1, 32'h1002, 32'hCAFEBEEF, 32'h11223344, 0, 0, 0, 32'hBEEF3344, 4, 1'b0};
        vecs[2] = '{1'b1, 32'h1000, 32'hCAFEBEEF, 32'h11223344, 0, 0, 0, 32'h1122BEEF, 4, 1'b0};
        vecs[3] = '{1'b0, 32'h1002, 32'h000000AB, 32'h11223344, 3, 2, 0, 32'h11AB3344, 9, 1'b0};
`ifdef MISALIGN_TRAP_EN
        vecs[4] = '{1'b1, 32'h1001, 32'hCAFEBEEF, 32'h11223344, 0, 0, 0, 32'h11223344, 1, 1'b1};
`else
        vecs[4] = '{1'b1, 32'h1001, 32'hCAFEBEEF, 32'h11223344, 0, 0, 0, 32'h1122BEEF, 4, 1'b0};
`endif
        vecs[5] = '{1'b0, 32'h1003, 32'h000000AB, 32'h11223344, 0, 0, 2, 32'hAB223344, 6, 1'b0};
        vecs[6] = '{1'b0, 32'h1000, 32'h123456AB, 32'h11223344, 1, 0, 0, 32'h112233AB, 5, 1'b0};
        vecs[7] = '{1'b0, 32'h1005, 32'hFFFFFFAB, 32'h11223344, 0, 1, 0, 32'h1122AB44, 5, 1'b0};

        reset = 1'b1; clk_enable = 1'b1; req = 1'b0; req_half = 1'b0;
        req_addr = '0; req_data = '0; mem_readdata = '0; mem_waitrequest = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset strobes", {mem_read, mem_write, stall, done, misalign}, 0);
        chk("reset address", mem_address, 0);
        chk("reset wdata", mem_writedata, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            mem[vecs[i].addr[5:2]] = vecs[i].init;
            do_store(vecs[i].half, vecs[i].addr, vecs[i].data, vecs[i].rw, vecs[i].ww,
                     vecs[i].gap, vecs[i].exp_word, vecs[i].exp_lat, vecs[i].exp_trap,
                     $sformatf("vec%0d", i));
        end

        // Reset while WRITE is stretched by waitrequest.
        mem[0] = 32'h11223344;
        req = 1'b1; req_half = 1'b0; req_addr = 32'h1000; req_data = 32'h55;
        n = 0; wseen = 0;
        while (wseen < 2 && n < 50) begin
            @(negedge clk);
            n++;
            mem_readdata = mem[0];
            mem_waitrequest = mem_write;
            if (mem_write) wseen++;
        end
        chk("rst_mid reached_write", wseen, 2);
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("rst_mid strobes", {mem_read, mem_write, stall, done, misalign}, 0);
        chk("rst_mid address", mem_address, 0);
        chk("rst_mid wdata", mem_writedata, 0);
        reset = 1'b0; mem_waitrequest = 1'b0;
        @(negedge clk);
        do_store(1'b0, 32'h1000, 32'h55, 0, 0, 0, 32'h11223355, 4, 1'b0, "after_rst");

        for (int k = 0; k < 40; k++) begin
            idx  = $urandom_range(0, 15);
            lane = 2'($urandom_range(0, 3));
            half = 1'($urandom_range(0, 1));
`ifdef MISALIGN_TRAP_EN
            if (half) lane[0] = 1'b0;
`endif
            addr = 32'h1000 + 32'(idx * 4) + {30'd0, lane};
            data = $urandom;
            init = $urandom;
            rw   = $urandom_range(0, 3);
            ww   = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            mem[idx] = init;
            do_store(half, addr, data, rw, ww, gap, ref_store(init, half, lane, data),
                     4 + rw + ww + gap, 1'b0, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
